// File: rtl/lupa_spi_pkg.sv
// Shared constants for the LUPA SPI register-upload path: field widths,
// end-of-table marker, sequencer state encoding and error codes.
package lupa_spi_pkg;

  localparam int         ADDR_W   = 7;
  localparam int         DATA_W   = 16;
  localparam logic [6:0] END_ADDR = 7'h7F;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FETCH = 4'd1,
    ST_CHECK = 4'd2,
    ST_ISSUE = 4'd3,
    ST_WAIT  = 4'd4,
    ST_GAP   = 4'd5,
    ST_DONE  = 4'd6,
    ST_ERR   = 4'd7,
    ST_ABRT  = 4'd8
  } seq_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_ABRT = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

endpackage

// File: rtl/lupa_cfg_rom.sv
// Banked LUPA configuration ROM: address {bank,idx}, registered read of {addr,data}.
// Table contents are generated at elaboration from rom_word().
module lupa_cfg_rom #(
  parameter int               ADDR_W   = 7,
  parameter int               DATA_W   = 16,
  parameter int               IDX_W    = 5,
  parameter int               BANK_W   = 4,
  parameter logic [ADDR_W-1:0] END_ADDR = 7'h7F
) (
  input  logic                       clk,
  input  logic [BANK_W+IDX_W-1:0]    addr,
  output logic [ADDR_W+DATA_W-1:0]   q
);

  localparam int DEPTH = 2 ** (BANK_W + IDX_W);
  localparam int W     = ADDR_W + DATA_W;

  // Bank 8: two-word reference table. Top bank: full table, no end marker.
  // Other banks b: b words at registers 0x20+idx, then the end marker.
  function automatic logic [W-1:0] rom_word(input int unsigned bank, input int unsigned idx);
    logic [W-1:0] w;
    w = {END_ADDR, DATA_W'(0)};
    if (bank == 8) begin
      if (idx == 0)      w = {ADDR_W'(8'h01), DATA_W'(16'h1234)};
      else if (idx == 1) w = {ADDR_W'(8'h02), DATA_W'(16'hABCD)};
    end else if (bank == 2 ** BANK_W - 1) begin
      w = {ADDR_W'(idx), DATA_W'(32'hF000 | idx)};
    end else if (idx < bank) begin
      w = {ADDR_W'(32'h20 + idx), DATA_W'((bank << 12) | idx)};
    end
    return w;
  endfunction

  logic [W-1:0] rom_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_mem[gi] = rom_word(gi >> IDX_W, gi % (2 ** IDX_W));
  end

  always_ff @(posedge clk) begin
    q <= rom_mem[addr];
  end

endmodule

// File: rtl/lupa_cfg_sequencer.sv
// Walks one bank of the config ROM and feeds each {addr,data} word to the SPI
// word shifter, with an inter-word gap, abort at word boundaries and a WAIT timeout.
module lupa_cfg_sequencer #(
  parameter int               ADDR_W   = lupa_spi_pkg::ADDR_W,
  parameter int               DATA_W   = lupa_spi_pkg::DATA_W,
  parameter int               IDX_W    = 5,
  parameter int               BANK_W   = 4,
  parameter int               GAP_CYC  = 4,
  parameter int               TMO_CYC  = 1024,
  parameter logic [ADDR_W-1:0] END_ADDR = lupa_spi_pkg::END_ADDR
) (
  input  logic              clock_20,
  input  logic              reset_n,
  input  logic              cfg_req,
  input  logic [BANK_W-1:0] cfg_bank,
  input  logic              abort,
  output logic              word_start,
  output logic [ADDR_W-1:0] word_addr,
  output logic [DATA_W-1:0] word_data,
  input  logic              word_done,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  word_idx
);

  import lupa_spi_pkg::*;

  localparam int TMO_W = $clog2(TMO_CYC);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  seq_state_t               state_reg, state_next;
  logic [BANK_W-1:0]        bank_reg, bank_next;
  logic [IDX_W-1:0]         idx_next;
  logic [GAP_W-1:0]         gap_reg, gap_next;
  logic [TMO_W-1:0]         tmo_reg, tmo_next;
  logic                     abort_pend_reg, abort_pend_next;
  logic [ADDR_W-1:0]        word_addr_next;
  logic [DATA_W-1:0]        word_data_next;
  logic [1:0]               err_code_next;
  logic [ADDR_W+DATA_W-1:0] rom_q;
  logic [ADDR_W-1:0]        rom_addr;
  logic [DATA_W-1:0]        rom_data;

  lupa_cfg_rom #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W),
    .BANK_W  (BANK_W),
    .END_ADDR(END_ADDR)
  ) u_rom (
    .clk (clock_20),
    .addr({bank_reg, word_idx}),
    .q   (rom_q)
  );

  assign rom_addr = rom_q[ADDR_W+DATA_W-1:DATA_W];
  assign rom_data = rom_q[DATA_W-1:0];

  always_comb begin
    state_next     = state_reg;
    bank_next      = bank_reg;
    idx_next       = word_idx;
    gap_next       = gap_reg;
    tmo_next       = tmo_reg;
    word_addr_next = word_addr;
    word_data_next = word_data;
    err_code_next  = ERR_NONE;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_req) begin
          bank_next  = cfg_bank;
          idx_next   = '0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_CHECK;
      ST_CHECK: begin
        if (rom_addr == END_ADDR) begin
          state_next = ST_DONE;
        end else begin
          word_addr_next = rom_addr;
          word_data_next = rom_data;
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (word_done) begin
          if (abort_pend_reg) begin
            state_next    = ST_ABRT;
            err_code_next = ERR_ABRT;
          end else if (word_idx == {IDX_W{1'b1}}) begin
            state_next    = ST_ERR;
            err_code_next = ERR_OVF;
          end else begin
            // The word_done cycle itself is the first idle cycle of the gap.
            idx_next   = word_idx + IDX_W'(1);
            gap_next   = GAP_W'(1);
            state_next = (GAP_CYC > 1) ? ST_GAP : ST_FETCH;
          end
        end else if (tmo_reg == TMO_W'(TMO_CYC - 1)) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TMO;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      ST_GAP: begin
        if (abort_pend_reg) begin
          state_next    = ST_ABRT;
          err_code_next = ERR_ABRT;
        end else if (gap_reg >= GAP_W'(GAP_CYC - 1)) begin
          state_next = ST_FETCH;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    abort_pend_next = (state_next == ST_IDLE) ? 1'b0
                    : (abort_pend_reg | (abort & (state_reg != ST_IDLE)));
  end

  always_ff @(posedge clock_20 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      bank_reg       <= '0;
      word_idx       <= '0;
      gap_reg        <= '0;
      tmo_reg        <= '0;
      abort_pend_reg <= 1'b0;
      word_start     <= 1'b0;
      word_addr      <= '0;
      word_data      <= '0;
      busy           <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
      err_code       <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      bank_reg       <= bank_next;
      word_idx       <= idx_next;
      gap_reg        <= gap_next;
      tmo_reg        <= tmo_next;
      abort_pend_reg <= abort_pend_next;
      // Status pulses line up with the terminal state; word_start trails ISSUE by one.
      word_start     <= (state_reg == ST_ISSUE);
      word_addr      <= word_addr_next;
      word_data      <= word_data_next;
      busy           <= (state_next != ST_IDLE);
      cfg_done       <= (state_next == ST_DONE);
      cfg_err        <= (state_next == ST_ERR) || (state_next == ST_ABRT);
      err_code       <= err_code_next;
    end
  end

endmodule

// File: tb/tb_lupa_cfg_sequencer.sv
// Randomized and directed bench for lupa_cfg_sequencer with a 40-cycle shifter
// model and a table-driven reference for word contents, timing and outcome.
module tb_lupa_cfg_sequencer;

  localparam int GAP   = 4;
  localparam int TMO   = 1024;
  localparam int SHIFT = 40;

  logic        clock_20 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        cfg_req  = 1'b0;
  logic [3:0]  cfg_bank = 4'd0;
  logic        abort    = 1'b0;
  logic        word_done = 1'b0;
  logic        word_start;
  logic [6:0]  word_addr;
  logic [15:0] word_data;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [1:0]  err_code;
  logic [4:0]  word_idx;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  lupa_cfg_sequencer #(
    .IDX_W  (5),
    .BANK_W (4),
    .GAP_CYC(GAP),
    .TMO_CYC(TMO)
  ) dut (
    .clock_20  (clock_20),
    .reset_n   (reset_n),
    .cfg_req   (cfg_req),
    .cfg_bank  (cfg_bank),
    .abort     (abort),
    .word_start(word_start),
    .word_addr (word_addr),
    .word_data (word_data),
    .word_done (word_done),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_code  (err_code),
    .word_idx  (word_idx)
  );

  always #20 clock_20 = ~clock_20;
  always @(posedge clock_20) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Expected ROM table as described for the board: bank 8 is the two-word
  // reference, bank 15 is 32 words with no end marker, bank b<15 holds b words.
  function automatic int tb_addr(input int bank, input int idx);
    if (bank == 8) return (idx == 0) ? 1 : (idx == 1) ? 2 : 127;
    if (bank == 15) return idx;
    return (idx < bank) ? 32 + idx : 127;
  endfunction

  function automatic int tb_data(input int bank, input int idx);
    if (bank == 8) return (idx == 0) ? 'h1234 : (idx == 1) ? 'hABCD : 0;
    if (bank == 15) return 'hF000 + idx;
    return (idx < bank) ? bank * 4096 + idx : 0;
  endfunction

  // One upload: abort_word/hold_word < 0 disable abort / withheld word_done;
  // req2_off > 0 fires a second cfg_req that far into the run.
  task automatic run_seq(input int bank, input int abort_word, input int abort_off,
                         input int hold_word, input int req2_off, input string tag);
    int n, exp_words, exp_kind, exp_t, exp_idx;
    int t0, t, next_ws, seen, done_at, abort_at, last_ws, last_done, term_t, term_kind;
    bit got_term;
    n = 0;
    while (n < 32 && tb_addr(bank, n) != 127) n++;
    if (hold_word >= 0 && hold_word < n)        begin exp_words = hold_word + 1;  exp_kind = 1; end
    else if (abort_word >= 0 && abort_word < n) begin exp_words = abort_word + 1; exp_kind = 2; end
    else if (n < 32)                            begin exp_words = n;              exp_kind = 0; end
    else                                        begin exp_words = 32;             exp_kind = 3; end

    @(negedge clock_20);
    t0 = cyc;
    cfg_req  = 1'b1;
    cfg_bank = 4'(bank);
    next_ws = t0 + 4; seen = 0; done_at = -1; abort_at = -1;
    last_ws = -1; last_done = -1; term_t = -1; term_kind = -1; got_term = 0;
    for (int i = 0; i < 3000 && !got_term; i++) begin
      @(negedge clock_20);
      t = cyc;
      cfg_req = 1'b0; word_done = 1'b0; abort = 1'b0;
      if (t == t0 + 1) check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
      if (req2_off > 0 && t == t0 + req2_off) begin
        cfg_req  = 1'b1;
        cfg_bank = 4'hF;
      end
      if (word_start) begin
        check_val({tag, "_ws_cycle"}, 32'(t), 32'(next_ws));
        check_val({tag, "_ws_addr"}, 32'(word_addr), 32'(tb_addr(bank, seen)));
        check_val({tag, "_ws_data"}, 32'(word_data), 32'(tb_data(bank, seen)));
        check_val({tag, "_ws_idx"}, 32'(word_idx), 32'(seen));
        if (seen != hold_word) done_at = t + SHIFT;
        if (seen == abort_word) abort_at = t + abort_off;
        last_ws = t;
        seen++;
      end
      if (cfg_done || cfg_err) begin
        got_term  = 1;
        term_t    = t;
        term_kind = cfg_done ? 0 : int'(err_code);
      end
      word_done = (t == done_at);
      abort     = (t == abort_at);
      if (word_done) begin
        next_ws   = t + GAP + 3;
        last_done = t;
      end
    end

    if (!got_term) begin
      check_val({tag, "_terminal_seen"}, 32'd0, 32'd1);
    end else begin
      case (exp_kind)
        0:       exp_t = (exp_words == 0) ? t0 + 3 : last_done + GAP + 2;
        1:       exp_t = last_ws + TMO;
        default: exp_t = last_done + 1;
      endcase
      exp_idx = (exp_kind == 0) ? exp_words : exp_words - 1;
      check_val({tag, "_status"}, 32'(term_kind), 32'(exp_kind));
      check_val({tag, "_status_cycle"}, 32'(term_t), 32'(exp_t));
      check_val({tag, "_words_sent"}, 32'(seen), 32'(exp_words));
      @(negedge clock_20);
      cfg_req = 1'b0; word_done = 1'b0; abort = 1'b0;
      check_val({tag, "_busy_fall"}, 32'(busy), 32'd0);
      check_val({tag, "_final_idx"}, 32'(word_idx), 32'(exp_idx));
      if (exp_words > 0)
        check_val({tag, "_addr_hold"}, 32'(word_addr), 32'(tb_addr(bank, exp_words - 1)));
    end
    $display("run %s: bank %0d words %0d status %0d at cycle %0d", tag, bank, seen, term_kind, term_t);
  endtask

  initial begin
    int active, bank, aw;
    reset_n = 1'b0;
    repeat (3) @(negedge clock_20);
    check_val("reset_ctrl", {27'd0, busy, word_start, cfg_done, cfg_err, 1'b0}, 32'd0);
    check_val("reset_code_idx", {25'd0, err_code, word_idx}, 32'd0);
    check_val("reset_word", {9'd0, word_addr, word_data}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock_20);

    run_seq(8, -1, 0, -1, 0, "bank8_two_words");
    run_seq(0, -1, 0, -1, 0, "empty_bank");
    run_seq(8, -1, 0, 0, 0, "timeout");
    run_seq(3, 0, 10, -1, 0, "abort_word1");
    run_seq(15, -1, 0, -1, 0, "overflow32");

    // Reset in the middle of WAIT for the first word of bank 8.
    @(negedge clock_20);
    cfg_req = 1'b1; cfg_bank = 4'd8;
    @(negedge clock_20);
    cfg_req = 1'b0;
    repeat (15) @(negedge clock_20);
    check_val("pre_reset_addr", 32'(word_addr), 32'h01);
    reset_n = 1'b0;
    #1;
    check_val("midrst_ctrl", {27'd0, busy, word_start, cfg_done, cfg_err, 1'b0}, 32'd0);
    check_val("midrst_word", {9'd0, word_addr, word_data}, 32'd0);
    check_val("midrst_idx", 32'(word_idx), 32'd0);
    repeat (3) @(negedge clock_20);
    reset_n = 1'b1;
    @(negedge clock_20);
    run_seq(8, -1, 0, -1, 10, "req_while_busy");
    active = 0;
    repeat (20) begin
      @(negedge clock_20);
      if (busy || word_start) active++;
    end
    check_val("req_not_queued", 32'(active), 32'd0);

    for (int r = 0; r < 10; r++) begin
      bank = int'($urandom_range(0, 14));
      aw   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, bank)) : -1;
      run_seq(bank, aw, int'($urandom_range(1, 38)), -1, 0, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
